// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus responder.
//   cycle_t      : decoded bus cycle kind
//   resp_state_t : responder handshake state
package z80_bus_pkg;

  localparam int unsigned IORF_DEPTH    = 8;
  localparam logic [7:0]  UNMAPPED_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_MEM_RD,
    CYC_MEM_WR,
    CYC_IO_RD,
    CYC_IO_WR,
    CYC_INTA
  } cycle_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    HOLD
  } resp_state_t;

  // Cycle kinds that return a byte to the core
  function automatic logic cyc_is_read(input cycle_t c);
    return c inside {CYC_MEM_RD, CYC_IO_RD, CYC_INTA};
  endfunction

endpackage

// File: rtl/z80_resp_ram.sv
// Single-port synchronous byte RAM, read-first, 1-cycle read latency, no reset.
//   CLK   : clock
//   we    : write enable
//   addr  : byte address (AW bits)
//   wdata : write byte
//   rdata : registered read byte
module z80_resp_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1 << AW) - 1];

  always_ff @(posedge CLK) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Memory/IO target on the Z80 pin bus: RAM, 8-entry IO register file,
// fixed interrupt vector, programmable wait states, INT_n generation.
//   CLK, RESET_n                 : clock, synchronous active-low reset
//   M1_n..RFSH_n, A, D_in        : bus strobes, address, write data
//   D_out, D_oe                  : read data and drive enable for the top's tristate
//   WAIT_n, INT_n                : wait request and interrupt request to the core
//   int_req                      : one-cycle pulse that sets the interrupt pending
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_AW      = 12,
  parameter logic [15:0] MEM_BASE    = 16'h0000,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [7:0]  INT_VECTOR  = 8'hFF
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        M1_n,
  input  logic        MREQ_n,
  input  logic        IORQ_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic        RFSH_n,
  input  logic [15:0] A,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        WAIT_n,
  output logic        INT_n,
  input  logic        int_req
);

  localparam int unsigned CNT_W   = 3;
  localparam int unsigned IORF_AW = $clog2(IORF_DEPTH);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait_cycles
    $error("WAIT_CYCLES must be in 0..7");
  end

  resp_state_t        state_q, state_d;
  cycle_t             cyc_q, cyc_d, cyc_det;
  logic [15:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         iorf_q [IORF_DEPTH];
  logic               wait_n_q, d_oe_q, src_ram_q, pending_q;
  logic [7:0]         dout_q, rd_byte, ram_rdata;
  logic               strobe_rel, ram_hit, io_hit, access_exit, ram_we;
  logic [IORF_AW-1:0] iorf_idx;

  // Bus cycle decode; INTA first since it overlaps the M1 and IORQ patterns
  always_comb begin
    cyc_det = CYC_NONE;
    if (!M1_n && !IORQ_n)                 cyc_det = CYC_INTA;
    else if (!IORQ_n && !RD_n && M1_n)    cyc_det = CYC_IO_RD;
    else if (!IORQ_n && !WR_n)            cyc_det = CYC_IO_WR;
    else if (!MREQ_n && !RD_n && RFSH_n)  cyc_det = CYC_MEM_RD;
    else if (!MREQ_n && !WR_n)            cyc_det = CYC_MEM_WR;
  end

  // Release of the strobe that owns the latched cycle
  always_comb begin
    strobe_rel = 1'b1;
    case (cyc_q)
      CYC_MEM_RD, CYC_IO_RD: strobe_rel = RD_n;
      CYC_MEM_WR, CYC_IO_WR: strobe_rel = WR_n;
      CYC_INTA:              strobe_rel = IORQ_n;
      default:               strobe_rel = 1'b1;
    endcase
  end

  // Handshake FSM next state
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cyc_det != CYC_NONE) begin
          cyc_d  = cyc_det;
          addr_d = A;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (strobe_rel)          state_d = IDLE;
        else if (cnt_q == '0)    state_d = ACCESS;
        else                     cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS:  state_d = HOLD;
      HOLD:    if (strobe_rel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ram_hit     = (addr_q >> MEM_AW) == (MEM_BASE >> MEM_AW);
  assign io_hit      = addr_q[7:0] < 8'(IORF_DEPTH);
  assign iorf_idx    = addr_q[IORF_AW-1:0];
  assign access_exit = (state_q == ACCESS);
  assign ram_we      = access_exit && (cyc_q == CYC_MEM_WR) && ram_hit;

  // Non-RAM read byte; RAM reads come straight from the RAM output register
  always_comb begin
    rd_byte = UNMAPPED_BYTE;
    case (cyc_q)
      CYC_IO_RD: if (io_hit) rd_byte = iorf_q[iorf_idx];
      CYC_INTA:  rd_byte = INT_VECTOR;
      default:   rd_byte = UNMAPPED_BYTE;
    endcase
  end

  z80_resp_ram #(.AW(MEM_AW)) u_ram (
    .CLK   (CLK),
    .we    (ram_we),
    .addr  (addr_q[MEM_AW-1:0]),
    .wdata (D_in),
    .rdata (ram_rdata)
  );

  // State, registered outputs, IO register file and interrupt pending
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q   <= IDLE;
      cyc_q     <= CYC_NONE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wait_n_q  <= 1'b1;
      d_oe_q    <= 1'b0;
      dout_q    <= '0;
      src_ram_q <= 1'b0;
      pending_q <= 1'b0;
      for (int i = 0; i < IORF_DEPTH; i++) iorf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wait_n_q <= (state_d != WAIT);
      d_oe_q   <= (state_d == HOLD) && cyc_is_read(cyc_q);
      if (access_exit && cyc_is_read(cyc_q)) begin
        src_ram_q <= (cyc_q == CYC_MEM_RD) && ram_hit;
        dout_q    <= rd_byte;
      end
      if (access_exit && (cyc_q == CYC_IO_WR) && io_hit) iorf_q[iorf_idx] <= D_in;
      // A new request on the acknowledge edge keeps the interrupt pending
      if (int_req)                                   pending_q <= 1'b1;
      else if (access_exit && (cyc_q == CYC_INTA))   pending_q <= 1'b0;
    end
  end

  // addr_q is stable from detect through HOLD, so the RAM output holds the byte
  assign D_out  = src_ram_q ? ram_rdata : dout_q;
  assign D_oe   = d_oe_q;
  assign WAIT_n = wait_n_q;
  assign INT_n  = ~pending_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Randomized scoreboard bench for z80_bus_responder with a behavioural memory/IO model.
module tb_z80_bus_responder;
  import z80_bus_pkg::*;

  localparam int         N   = 2;
  localparam logic [7:0] VEC = 8'hC7;

  logic        CLK = 1'b0;
  logic        RESET_n, M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n, int_req;
  logic [15:0] A;
  logic [7:0]  D_in, D_out;
  logic        D_oe, WAIT_n, INT_n;

  always #5 CLK = ~CLK;

  z80_bus_responder #(
    .MEM_AW(12), .MEM_BASE(16'h0000), .WAIT_CYCLES(N), .INT_VECTOR(VEC)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .M1_n(M1_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n),
    .RD_n(RD_n), .WR_n(WR_n), .RFSH_n(RFSH_n), .A(A), .D_in(D_in),
    .D_out(D_out), .D_oe(D_oe), .WAIT_n(WAIT_n), .INT_n(INT_n), .int_req(int_req)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  ram_m [4096];
  logic [7:0]  iorf_m [8];
  bit          pending_m;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;
  bit          doe_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what the target should return for a read
  function automatic logic [7:0] exp_read(input cycle_t kind, input logic [15:0] addr);
    if (kind == CYC_INTA) return VEC;
    if (kind == CYC_MEM_RD) return (addr[15:12] == 4'h0) ? ram_m[addr[11:0]] : 8'hFF;
    return (addr[7:0] < 8'd8) ? iorf_m[addr[2:0]] : 8'hFF;
  endfunction

  // Monitor: each rising D_oe presents one read byte
  always @(negedge CLK) begin
    if (D_oe === 1'b1 && !doe_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL read_unexpected d_out=%02h", D_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("read_data", 32'(D_out), 32'(mon_exp));
      end
    end
    doe_prev = (D_oe === 1'b1);
  end

  task automatic set_idle();
    M1_n = 1'b1; MREQ_n = 1'b1; IORQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1; RFSH_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // mode: 0 normal, 1 int_req on the acknowledge edge, 2 reset while in HOLD
  task automatic bus_cycle(input cycle_t kind, input logic [15:0] addr, input logic [7:0] wd,
                           input bit m1, input int mode);
    int k, waits;
    bit done, rd;
    rd = kind inside {CYC_MEM_RD, CYC_IO_RD, CYC_INTA};
    set_idle();
    A = addr;
    D_in = wd;
    case (kind)
      CYC_MEM_RD: begin MREQ_n = 1'b0; RD_n = 1'b0; M1_n = !m1; end
      CYC_MEM_WR: begin MREQ_n = 1'b0; WR_n = 1'b0; end
      CYC_IO_RD:  begin IORQ_n = 1'b0; RD_n = 1'b0; end
      CYC_IO_WR:  begin IORQ_n = 1'b0; WR_n = 1'b0; end
      default:    begin M1_n = 1'b0; IORQ_n = 1'b0; end
    endcase
    if (rd) exp_q.push_back(exp_read(kind, addr));
    k = 0; waits = 0; done = 1'b0;
    while (!done && k < 50) begin
      tick();
      k++;
      if (WAIT_n === 1'b0) waits++;
      int_req = (mode == 1 && k == N + 1);
      if (rd) done = (D_oe === 1'b1);
      else    done = (k == N + 2);
    end
    int_req = 1'b0;
    if (!done) chk("cycle_timeout", 32'(k), 32'(N + 2));
    chk("wait_states", 32'(waits), 32'(N));
    if (rd) chk("read_latency", 32'(k), 32'(N + 2));
    if (kind == CYC_MEM_WR && addr[15:12] == 4'h0) ram_m[addr[11:0]] = wd;
    if (kind == CYC_IO_WR && addr[7:0] < 8'd8) iorf_m[addr[2:0]] = wd;
    if (kind == CYC_INTA) pending_m = (mode == 1);
    if (mode == 2) begin
      RESET_n = 1'b0;
      set_idle();
      tick();
      chk("rst_doe", 32'(D_oe), 32'(0));
      chk("rst_waitn", 32'(WAIT_n), 32'(1));
      chk("rst_intn", 32'(INT_n), 32'(1));
      chk("rst_dout", 32'(D_out), 32'(0));
      RESET_n = 1'b1;
      for (int i = 0; i < 8; i++) iorf_m[i] = 8'h00;
      pending_m = 1'b0;
      tick();
      return;
    end
    if (rd) begin
      tick();
      chk("oe_held", 32'(D_oe), 32'(1));
    end
    set_idle();
    tick();
    chk("release_oe", 32'(D_oe), 32'(0));
    chk("release_waitn", 32'(WAIT_n), 32'(1));
    chk("int_n", 32'(INT_n), 32'(!pending_m));
    tick();
  endtask

  task automatic int_pulse();
    int_req = 1'b1;
    tick();
    int_req = 1'b0;
    pending_m = 1'b1;
    chk("int_pulse", 32'(INT_n), 32'(0));
  endtask

  task automatic abort_write(input logic [15:0] addr, input logic [7:0] wd);
    set_idle();
    A = addr; D_in = wd; MREQ_n = 1'b0; WR_n = 1'b0;
    tick();
    chk("abort_wait_low", 32'(WAIT_n), 32'(0));
    set_idle();
    tick();
    chk("abort_waitn", 32'(WAIT_n), 32'(1));
    chk("abort_doe", 32'(D_oe), 32'(0));
    tick();
  endtask

  task automatic refresh_cycle();
    set_idle();
    A = 16'h007F; MREQ_n = 1'b0; RFSH_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rfsh_waitn", 32'(WAIT_n), 32'(1));
    end
    set_idle();
    tick();
    chk("rfsh_doe", 32'(D_oe), 32'(0));
  endtask

  function automatic logic [15:0] rand_mem_addr();
    if ($urandom_range(0, 3) == 0) return 16'($urandom_range(16'h1000, 16'hFFFF));
    return 16'($urandom_range(0, 63));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    set_idle();
    A = '0; D_in = '0; int_req = 1'b0; RESET_n = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_waitn", 32'(WAIT_n), 32'(1));
    chk("reset_doe", 32'(D_oe), 32'(0));
    chk("reset_dout", 32'(D_out), 32'(0));
    chk("reset_intn", 32'(INT_n), 32'(1));
    RESET_n = 1'b1;
    for (int i = 0; i < 8; i++) iorf_m[i] = 8'h00;
    pending_m = 1'b0;
    tick();

    for (int i = 0; i < 64; i++) bus_cycle(CYC_MEM_WR, 16'(i), 8'($urandom), 1'b0, 0);

    bus_cycle(CYC_MEM_WR, 16'h0012, 8'hA5, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0012, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_WR, 16'h0FFF, 8'h3C, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0FFF, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h1000, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h8000, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_WR, 16'h8000, 8'h77, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0000, 8'h00, 1'b0, 0);
    bus_cycle(CYC_IO_WR, 16'h1203, 8'h5A, 1'b0, 0);
    bus_cycle(CYC_IO_RD, 16'h0003, 8'h00, 1'b0, 0);
    bus_cycle(CYC_IO_RD, 16'h0040, 8'h00, 1'b0, 0);
    bus_cycle(CYC_IO_WR, 16'h0008, 8'h99, 1'b0, 0);
    bus_cycle(CYC_IO_RD, 16'h0008, 8'h00, 1'b0, 0);
    bus_cycle(CYC_IO_RD, 16'h0000, 8'h00, 1'b0, 0);
    refresh_cycle();

    int_pulse();
    bus_cycle(CYC_INTA, 16'h0000, 8'h00, 1'b0, 0);
    int_pulse();
    bus_cycle(CYC_INTA, 16'h0000, 8'h00, 1'b0, 1);
    bus_cycle(CYC_INTA, 16'h0000, 8'h00, 1'b0, 0);

    abort_write(16'h0012, 8'h00);
    bus_cycle(CYC_MEM_RD, 16'h0012, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0012, 8'h00, 1'b1, 0);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0, 1: bus_cycle(CYC_MEM_RD, rand_mem_addr(), 8'h00, 1'($urandom_range(0, 1)), 0);
        2:    bus_cycle(CYC_MEM_WR, rand_mem_addr(), 8'($urandom), 1'b0, 0);
        3:    bus_cycle(CYC_IO_RD, {8'($urandom), 8'($urandom_range(0, 15))}, 8'h00, 1'b0, 0);
        4:    bus_cycle(CYC_IO_WR, {8'($urandom), 8'($urandom_range(0, 15))}, 8'($urandom), 1'b0, 0);
        default: begin
          if ($urandom_range(0, 1) == 1) int_pulse();
          bus_cycle(CYC_INTA, 16'($urandom), 8'h00, 1'b0, 0);
        end
      endcase
    end

    int_pulse();
    bus_cycle(CYC_IO_WR, 16'h0005, 8'hEE, 1'b0, 0);
    bus_cycle(CYC_IO_RD, 16'h0003, 8'h00, 1'b0, 2);
    for (int p = 0; p < 8; p++) bus_cycle(CYC_IO_RD, 16'(p), 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0012, 8'h00, 1'b0, 0);
    bus_cycle(CYC_MEM_RD, 16'h0FFF, 8'h00, 1'b0, 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synthesizable memory/IO target on the Z80 pin bus. It decodes bus cycles driven by `z80_top`:
- opcode fetch, memory read/write, IO read/write, interrupt acknowledge.

It serves each cycle from internal RAM, an 8-entry IO register file or a fixed interrupt vector, with programmable wait-state insertion. It drives `INT_n` from a bench-side request. It sits beside the core in the bench and FPGA top. The top level owns the tristate on `D`; this block uses split data in/out/enable.

## Interface
Parameters:
- MEM_AW, 12, RAM address width (2^MEM_AW bytes)
- MEM_BASE, 16'h0000, RAM base; hit when A[15:MEM_AW] == MEM_BASE[15:MEM_AW]
- WAIT_CYCLES, 1, wait states per cycle, 0..7
- INT_VECTOR, 8'hFF, byte returned on interrupt acknowledge

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock, all state on rising edge
- RESET_n  in  1  synchronous active-low reset
- M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n  in  1 each  Z80 bus strobes
- A  in  16  Z80 address
- D_in  in  8  data from bus (write cycles)
- D_out  out  8  read data
- D_oe  out  1  1 = top drives D_out onto D
- WAIT_n  out  1  wait request to core
- INT_n  out  1  maskable interrupt request to core
- int_req  in  1  one-cycle pulse, sets interrupt pending

## Operation
- Request decode, sampled each edge in IDLE:
  - MEM_RD: MREQ_n=0, RD_n=0, RFSH_n=1. M1 fetch is treated identically.
  - MEM_WR: MREQ_n=0, WR_n=0.
  - IO_RD: IORQ_n=0, RD_n=0, M1_n=1.
  - IO_WR: IORQ_n=0, WR_n=0.
  - INTA: M1_n=0, IORQ_n=0.
  - Refresh (MREQ_n=0, RFSH_n=0) is ignored.
- On detect, latch A and cycle type.
- FSM states:
  - IDLE: on detect, go to WAIT if WAIT_CYCLES>0 (cnt=WAIT_CYCLES-1), else ACCESS.
  - WAIT: WAIT_n=0. If cnt==0 go to ACCESS, else cnt-1. If the active strobe deasserts, go to IDLE (abort, no write).
  - ACCESS: one cycle. The RAM read issues on the latched address. Writes commit D_in at the exit edge. Always go to HOLD.
  - HOLD: D_oe=1 for read types. When the active strobe deasserts (RD_n for reads, WR_n for writes, IORQ_n for INTA), go to IDLE with D_oe=0.
- Read data sources:
  - RAM hit: the RAM byte.
  - IO port A[7:0] in 0x00..0x07: iorf[A[2:0]].
  - INTA: INT_VECTOR.
  - Unmapped memory or port: 8'hFF.
- Unmapped writes are dropped, but the handshake still completes.
- Interrupts:
  - int_req sets pending; INT_n = ~pending.
  - The ACCESS exit edge of an INTA clears pending.
  - If int_req arrives on the same edge, pending stays 1 (set wins).
- Reset:
  - Synchronous; takes effect mid-cycle from any state.
  - State→IDLE, WAIT_n=1, D_oe=0, D_out=8'h00, INT_n=1, pending=0, iorf cleared.
  - RAM contents are not reset.

## Timing
- Edge E0 = detect. With N=WAIT_CYCLES:
  - WAIT_n low from E0 for N cycles (E0..E0+N-1 exits), high again at E0+N.
  - ACCESS during E0+N..E0+N+1.
  - D_out valid and D_oe=1 from edge E0+N+1.
- Read latency, detect to data: N+1 clocks. With N=0, WAIT_n never drops.
- Write: D_in sampled at edge E0+N+1. The core must hold WR_n low and data stable until then.
- D_oe drops on the edge that samples strobe release. A new request is accepted the following edge; there is no back-to-back overlap.
- An abort during WAIT releases WAIT_n on the edge sampling release.
- WAIT_CYCLES outside 0..7 is an elaboration error.

## Structure
- Package z80_bus_pkg holds:
  - enum cycle_t {CYC_NONE, CYC_MEM_RD, CYC_MEM_WR, CYC_IO_RD, CYC_IO_WR, CYC_INTA}
  - enum resp_state_t {IDLE, WAIT, ACCESS, HOLD}
  - localparams IORF_DEPTH=8 and UNMAPPED_BYTE=8'hFF
- Sub-module z80_resp_ram: single-port synchronous RAM, parameter AW, with ports CLK, we, addr, wdata, rdata. 1-cycle read latency; no reset.

## Test plan
- MEM_WR 16'h0012 data 8'hA5, then MEM_RD 16'h0012 with WAIT_CYCLES=1 → WAIT_n low exactly 1 clock, D_out=8'hA5, D_oe high until RD_n rises.
- MEM_RD 16'h8000 (unmapped, MEM_AW=12) → D_out=8'hFF, normal handshake. MEM_WR there → RAM unchanged.
- IO_WR port 8'h03 data 8'h5A, IO_RD port 8'h03 → 8'h5A. IO_RD port 8'h40 → 8'hFF. A cycle with MREQ_n=0, RFSH_n=0 is ignored, WAIT_n stays 1.
- int_req pulse → INT_n=0 next edge. INTA (M1_n=0, IORQ_n=0) → D_out=8'hFF, INT_n=1 after ACCESS. int_req coincident with ACCESS exit → INT_n stays 0.
- WAIT_CYCLES=3, MEM_WR with WR_n released during WAIT → return to IDLE, WAIT_n=1, RAM byte unchanged.
- RESET_n=0 for one clock during HOLD of an IO_RD → next edge: D_oe=0, WAIT_n=1, INT_n=1, iorf all 0, RAM data preserved on re-read.
